// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: instruction-memory request/response bus between fetch and imem
interface if_fetch_stage_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  modport master(output imem_req_o, imem_addr_o, input imem_rvalid_i, imem_rdata_i);
  modport slave(input imem_req_o, imem_addr_o, output imem_rvalid_i, imem_rdata_i);
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC, single-outstanding imem fetch, IF/ID register with skid buffer and redirect
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  if_fetch_stage_if.master  imem,
  output logic [31:0]       PC_o,
  output logic [31:0]       instID_o,
  output logic              valid_o
);
  localparam logic [1:0] ISSUE = 2'd0, WAIT = 2'd1, DRAIN = 2'd2, HOLD = 2'd3;
  logic [1:0]  state;
  logic [31:0] pc_q, skid_pc, skid_inst;
  logic        rsp, keep;
  assign rsp = state == WAIT && imem.imem_rvalid_i;
  assign keep = stall_i && !flush_i;
  assign imem.imem_req_o = state == ISSUE && !rst_i;
  assign imem.imem_addr_o = pc_q;
  // HOLD means the skid buffer is full; leaving HOLD empties it
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state     <= ISSUE;
      pc_q      <= RESET_PC;
      skid_pc   <= '0;
      skid_inst <= '0;
      PC_o      <= '0;
      instID_o  <= NOP_INST;
      valid_o   <= 1'b0;
    end else if (redirect_i) begin
      pc_q     <= redirect_pc_i & ~32'd3;
      instID_o <= NOP_INST;
      valid_o  <= 1'b0;
      state    <= (state == ISSUE || ((state == WAIT || state == DRAIN) && !imem.imem_rvalid_i)) ? DRAIN : ISSUE;
    end else begin
      if (flush_i) begin
        instID_o <= NOP_INST;
        valid_o  <= 1'b0;
      end else if (!stall_i && rsp) begin
        PC_o     <= pc_q;
        instID_o <= imem.imem_rdata_i;
        valid_o  <= 1'b1;
      end else if (!stall_i && state == HOLD) begin
        PC_o     <= skid_pc;
        instID_o <= skid_inst;
        valid_o  <= 1'b1;
      end
      if (rsp) begin
        pc_q      <= pc_q + 32'd4;
        skid_pc   <= pc_q;
        skid_inst <= imem.imem_rdata_i;
      end
      state <= state == ISSUE ? WAIT :
               rsp ? (keep ? HOLD : ISSUE) :
               (state == DRAIN && imem.imem_rvalid_i) ? ISSUE :
               (state == HOLD && !keep) ? ISSUE : state;
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed checks of fetch timing, stall skid, redirect, wrap and flush
module tb_if_fetch_stage;
  logic        clk_i = 1'b0, rst_i = 1'b1, stall_i = 1'b0, flush_i = 1'b0, redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] PC_o, instID_o;
  logic        valid_o;
  int          checks = 0, errors = 0, lat = 1, cnt = 0;
  logic [31:0] addr_l = '0;
  if_fetch_stage_if imem();
  if_fetch_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .imem(imem),
    .PC_o(PC_o), .instID_o(instID_o), .valid_o(valid_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 32'h0 ? 32'h0050_0093 : a == 32'h4 ? 32'h0010_0113 : a ^ 32'h1357_0000;
  endfunction
  initial begin
    imem.imem_rvalid_i = 1'b0;
    imem.imem_rdata_i = '0;
  end
  // memory model: answers a request seen in cycle N during cycle N+lat
  always @(negedge clk_i) begin
    imem.imem_rvalid_i = 1'b0;
    if (rst_i) cnt = 0;
    else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          imem.imem_rvalid_i = 1'b1;
          imem.imem_rdata_i = mem(addr_l);
        end
      end
      if (imem.imem_req_o) begin
        cnt = lat;
        addr_l = imem.imem_addr_o;
      end
    end
  end
  task automatic do_reset(input int l);
    rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #2 lat = l; rst_i = 1'b0;
    @(negedge clk_i);
  endtask
  task automatic test_reset;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (imem.imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %0h exp 0", imem.imem_req_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", valid_o); end
    checks++; if (instID_o !== 32'h13) begin errors++; $display("FAIL reset_inst got %h exp 00000013", instID_o); end
    checks++; if (PC_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", PC_o); end
  endtask
  task automatic test_basic;
    do_reset(1);
    checks++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h0) begin errors++; $display("FAIL basic_req0 got %0h/%h exp 1/0", imem.imem_req_o, imem.imem_addr_o); end
    @(negedge clk_i);
    checks++; if (imem.imem_req_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL basic_wait got req %0h valid %0h exp 0/0", imem.imem_req_o, valid_o); end
    @(negedge clk_i);
    checks++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h4) begin errors++; $display("FAIL basic_req4 got %0h/%h exp 1/4", imem.imem_req_o, imem.imem_addr_o); end
    checks++; if ({valid_o, PC_o, instID_o} !== {1'b1, 32'h0, 32'h0050_0093}) begin errors++; $display("FAIL basic_ifid0 got %0h %h %h exp 1 0 00500093", valid_o, PC_o, instID_o); end
    repeat (2) @(negedge clk_i);
    checks++; if ({valid_o, PC_o, instID_o} !== {1'b1, 32'h4, 32'h0010_0113}) begin errors++; $display("FAIL basic_ifid4 got %0h %h %h exp 1 4 00100113", valid_o, PC_o, instID_o); end
    checks++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h8) begin errors++; $display("FAIL basic_req8 got %0h/%h exp 1/8", imem.imem_req_o, imem.imem_addr_o); end
  endtask
  task automatic test_stall;
    do_reset(3);
    repeat (3) @(negedge clk_i);
    stall_i = 1'b1;
    @(negedge clk_i);
    checks++; if (imem.imem_req_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL stall_hold1 got req %0h valid %0h exp 0/0", imem.imem_req_o, valid_o); end
    @(negedge clk_i);
    checks++; if (imem.imem_req_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL stall_hold2 got req %0h valid %0h exp 0/0", imem.imem_req_o, valid_o); end
    stall_i = 1'b0;
    @(negedge clk_i);
    checks++; if ({valid_o, PC_o, instID_o} !== {1'b1, 32'h0, 32'h0050_0093}) begin errors++; $display("FAIL stall_skid got %0h %h %h exp 1 0 00500093", valid_o, PC_o, instID_o); end
    checks++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h4) begin errors++; $display("FAIL stall_next_req got %0h/%h exp 1/4", imem.imem_req_o, imem.imem_addr_o); end
    repeat (3) @(negedge clk_i);
    checks++; if (PC_o !== 32'h0) begin errors++; $display("FAIL stall_no_dup got PC %h exp 0", PC_o); end
    @(negedge clk_i);
    checks++; if ({valid_o, PC_o, instID_o} !== {1'b1, 32'h4, 32'h0010_0113}) begin errors++; $display("FAIL stall_after got %0h %h %h exp 1 4 00100113", valid_o, PC_o, instID_o); end
  endtask
  task automatic test_redirect_wait;
    do_reset(3);
    @(negedge clk_i);
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    @(negedge clk_i);
    redirect_i = 1'b0;
    checks++; if (imem.imem_req_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL redir_drain got req %0h valid %0h exp 0/0", imem.imem_req_o, valid_o); end
    repeat (2) @(negedge clk_i);
    checks++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h100) begin errors++; $display("FAIL redir_req got %0h/%h exp 1/100", imem.imem_req_o, imem.imem_addr_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL redir_discard got valid %0h exp 0", valid_o); end
    repeat (4) @(negedge clk_i);
    checks++; if ({valid_o, PC_o, instID_o} !== {1'b1, 32'h100, 32'h1357_0100}) begin errors++; $display("FAIL redir_ifid got %0h %h %h exp 1 100 13570100", valid_o, PC_o, instID_o); end
  endtask
  task automatic test_redirect_rvalid;
    do_reset(1);
    @(negedge clk_i);
    redirect_i = 1'b1; redirect_pc_i = 32'h203;
    @(negedge clk_i);
    redirect_i = 1'b0;
    checks++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h200) begin errors++; $display("FAIL redrv_req got %0h/%h exp 1/200", imem.imem_req_o, imem.imem_addr_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL redrv_drop got valid %0h exp 0", valid_o); end
    repeat (2) @(negedge clk_i);
    checks++; if ({valid_o, PC_o, instID_o} !== {1'b1, 32'h200, 32'h1357_0200}) begin errors++; $display("FAIL redrv_ifid got %0h %h %h exp 1 200 13570200", valid_o, PC_o, instID_o); end
  endtask
  task automatic test_wrap;
    do_reset(1);
    @(negedge clk_i);
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    @(negedge clk_i);
    redirect_i = 1'b0;
    checks++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req_top got %0h/%h exp 1/fffffffc", imem.imem_req_o, imem.imem_addr_o); end
    repeat (2) @(negedge clk_i);
    checks++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_req_zero got %0h/%h exp 1/0", imem.imem_req_o, imem.imem_addr_o); end
    checks++; if ({valid_o, PC_o, instID_o} !== {1'b1, 32'hFFFF_FFFC, 32'hECA8_FFFC}) begin errors++; $display("FAIL wrap_ifid got %0h %h %h exp 1 fffffffc eca8fffc", valid_o, PC_o, instID_o); end
  endtask
  task automatic test_flush;
    do_reset(1);
    repeat (2) @(negedge clk_i);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL flush_pre got valid %0h exp 1", valid_o); end
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    checks++; if ({valid_o, PC_o, instID_o} !== {1'b0, 32'h0, 32'h13}) begin errors++; $display("FAIL flush_bubble got %0h %h %h exp 0 0 00000013", valid_o, PC_o, instID_o); end
    @(negedge clk_i);
    checks++; if ({valid_o, PC_o, instID_o} !== {1'b1, 32'h4, 32'h0010_0113}) begin errors++; $display("FAIL flush_continue got %0h %h %h exp 1 4 00100113", valid_o, PC_o, instID_o); end
    checks++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h8) begin errors++; $display("FAIL flush_req got %0h/%h exp 1/8", imem.imem_req_o, imem.imem_addr_o); end
  endtask
  task automatic test_async_reset;
    #1 rst_i = 1'b1;
    #1;
    checks++; if ({imem.imem_req_o, valid_o, PC_o, instID_o} !== {1'b0, 1'b0, 32'h0, 32'h13}) begin errors++; $display("FAIL async_reset got req %0h valid %0h %h %h exp 0 0 0 00000013", imem.imem_req_o, valid_o, PC_o, instID_o); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
